// File: rtl/inc_nibble_seq_pkg.sv
// Shared ALU definitions for the nibble-serial incrementer.
// Nibble width and controller state encoding.
package inc_nibble_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/inc_nibble_seq_inc4.sv
// Existing 4-bit incrementer cell.
// Outputs are undefined while en is low.
module inc_nibble_seq_inc4
  import inc_nibble_seq_pkg::*;
(
  input  logic             en,
  input  logic [NIB_W-1:0] a,
  output logic [NIB_W-1:0] s,
  output logic             c_out
);

  // add one when enabled, otherwise drive unknowns
  always_comb begin
    if (en) begin
      {c_out, s} = {1'b0, a} + (NIB_W+1)'(1);
    end else begin
      s     = 'x;
      c_out = 1'bx;
    end
  end

endmodule

// File: rtl/inc_nibble_seq.sv
// Nibble-serial incrementer: walks nibbles from LSB,
// stopping at the first one that does not carry.
module inc_nibble_seq
  import inc_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NIB_W*NIBBLES-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIB_W*NIBBLES-1:0]   out_data,
  output logic                       out_carry,
  output logic [$clog2(NIBBLES+1)-1:0] out_cycles
);

  localparam int DW = NIB_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam int CW = $clog2(NIBBLES + 1);

  state_t           state;
  state_t           state_n;
  logic [DW-1:0]    work;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    steps;
  logic             carry;

  logic             inc_en;
  logic [NIB_W-1:0] nib;
  logic [NIB_W-1:0] sum;
  logic             c_out;
  logic             accept;
  logic             last;

  inc_nibble_seq_inc4 u_inc (
    .en    (inc_en),
    .a     (nib),
    .s     (sum),
    .c_out (c_out)
  );

  assign accept = in_valid && in_ready;
  assign last   = (idx == IW'(NIBBLES - 1));

  // select the nibble addressed by idx
  always_comb begin
    nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        nib = work[i*NIB_W +: NIB_W];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state: carry only consulted while running
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (!c_out || last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // handshake and incrementer enable from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    inc_en    = (state == RUN);
  end

  // working operand, nibble index, step count, final carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      idx   <= '0;
      steps <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      work  <= in_data;
      idx   <= '0;
      steps <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IW'(i)) begin
          work[i*NIB_W +: NIB_W] <= sum;
        end
      end
      steps <= steps + CW'(1);
      if (c_out && !last) begin
        idx <= idx + IW'(1);
      end
      if (!c_out || last) begin
        carry <= c_out;
      end
    end
  end

  assign out_data   = work;
  assign out_carry  = carry;
  assign out_cycles = steps;

endmodule

// File: tb/tb_inc_nibble_seq.sv
// Bench for inc_nibble_seq: directed cases plus
// random traffic against a reference model.
module tb_inc_nibble_seq;

  localparam int N  = 4;
  localparam int DW = 4 * N;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_carry;
  logic [CW-1:0] out_cycles;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inc_nibble_seq #(.NIBBLES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry),
    .out_cycles (out_cycles)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void mdl(input  logic [DW-1:0] d,
                              output logic [DW-1:0] r,
                              output logic          c,
                              output int            k);
    logic [DW:0] t;
    t = {1'b0, d} + 1;
    r = t[DW-1:0];
    c = t[DW];
    k = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (((d >> (4 * i)) & 15) != 15) k = i + 1;
    end
  endfunction

  function automatic logic [DW-1:0] rand_op();
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[4*i +: 4] = ($urandom_range(0, 1) == 1) ?
                    4'hF : 4'($urandom);
    end
    return v;
  endfunction

  int            cyc = 0;
  bit            mon_en = 0;
  bit            m_busy = 0;
  int            m_due;
  logic [DW-1:0] m_d;
  logic          m_c;
  int            m_k;

  always @(negedge clk) begin
    bit exp_v;
    cyc++;
    if (!rst_n) begin
      m_busy = 0;
    end else if (mon_en) begin
      exp_v = m_busy && (cyc >= m_due);
      chk("mon_out_valid", out_valid, exp_v);
      chk("mon_in_ready", in_ready, !m_busy);
      if (exp_v) begin
        chk("mon_out_data", out_data, m_d);
        chk("mon_out_carry", out_carry, m_c);
        chk("mon_out_cycles", out_cycles, m_k);
      end
      if (exp_v && out_ready) begin
        m_busy = 0;
      end else if (!m_busy && in_valid) begin
        mdl(in_data, m_d, m_c, m_k);
        m_busy = 1;
        m_due  = cyc + m_k + 1;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask

  task automatic do_op(input  logic [DW-1:0] d,
                       output logic [DW-1:0] rd,
                       output logic          rc,
                       output int            rk,
                       output int            lat);
    out_ready = 1'b1;
    send(d);
    wait_valid(lat);
    rd = out_data;
    rc = out_carry;
    rk = int'(out_cycles);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          rc;
    int            rk;
    int            lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    mdl(16'h12FF, rd, rc, rk);
    chk("model_12ff_d", rd, 16'h1300);
    chk("model_12ff_c", rc, 0);
    chk("model_12ff_k", rk, 3);
    mdl(16'hFFFF, rd, rc, rk);
    chk("model_ffff_d", rd, 16'h0000);
    chk("model_ffff_c", rc, 1);
    chk("model_ffff_k", rk, 4);
    mdl(16'h0000, rd, rc, rk);
    chk("model_0000_k", rk, 1);

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_cycles", out_cycles, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    do_op(16'h0000, rd, rc, rk, lat);
    chk("z_data", rd, 16'h0001);
    chk("z_carry", rc, 0);
    chk("z_cycles", rk, 1);
    chk("z_lat", lat, 2);

    do_op(16'h12FF, rd, rc, rk, lat);
    chk("a_data", rd, 16'h1300);
    chk("a_carry", rc, 0);
    chk("a_cycles", rk, 3);
    chk("a_lat", lat, 4);

    do_op(16'hFFFF, rd, rc, rk, lat);
    chk("f_data", rd, 16'h0000);
    chk("f_carry", rc, 1);
    chk("f_cycles", rk, 4);
    chk("f_lat", lat, 5);

    out_ready = 1'b0;
    send(16'h0041);
    wait_valid(lat);
    rd = out_data;
    chk("h_data", rd, 16'h0042);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 16'h0007;
      @(negedge clk);
      chk("h_in_ready", in_ready, 0);
      chk("h_valid", out_valid, 1);
      chk("h_stable", out_data, rd);
      chk("h_cycles", out_cycles, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("h_after_ready", in_ready, 1);
    chk("h_after_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("h_pend_data", out_data, 16'h0008);
    chk("h_pend_lat", lat, 2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(16'h00FF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("r_async_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("r_no_valid", out_valid, 0);
      chk("r_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;
    do_op(16'h0005, rd, rc, rk, lat);
    chk("r_next_data", rd, 16'h0006);
    chk("r_next_cycles", rk, 1);

    do_op(16'h000F, rd, rc, rk, lat);
    chk("b1_data", rd, 16'h0010);
    chk("b1_cycles", rk, 2);
    do_op(16'hFFFE, rd, rc, rk, lat);
    chk("b2_data", rd, 16'hFFFF);
    chk("b2_cycles", rk, 1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 249) != 0);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
